div_reservation_station: RTL and testbench
==========================================

Name: div_reservation_station

Overview:
- Reservation station feeding the divider issue/exec stage.
- Holds dispatched divide ops until both operands are ready, snooping the CDB for tags it is waiting on.
- Presents the oldest ready op on the RS-side handshake: readyRS_o out, stallRS_i back.
- Sits between dispatch/rename and the divider issue/exec stage.

Parameters:
ROBsize, 32, number of ROB entries
ROBsizeLog, $clog2(ROBsize+1), tag width
RSsize, 4, number of station entries (>=2)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
dispatchValid_i  in  1  dispatch a new op this cycle
dispatchCommands_i  in  10  op commands
dispatchTag_i  in  ROBsizeLog  destination ROB tag
dispatchVal1_i / dispatchVal2_i  in  64 each  operand values (dividend / divisor)
dispatchRdy1_i / dispatchRdy2_i  in  1 each  operand value already valid
dispatchQ1_i / dispatchQ2_i  in  ROBsizeLog each  producer tag when not ready
full_o  out  1  count==RSsize
cdbValid_i  in  1  CDB broadcast valid
cdbTag_i  in  ROBsizeLog  broadcast tag
cdbVal_i  in  64  broadcast value
flush_i  in  1  discard all entries
readyRS_o  out  1  issue candidate present
stallRS_i  in  1  exec stage cannot accept
reservationStationVal1_o / reservationStationVal2_o  out  64 each  operands of issue candidate
reservationStationCommands_o  out  10  commands of candidate
reservationStationTag_o  out  ROBsizeLog  ROB tag of candidate

Behaviour:
- One clock; synchronous active-high reset. Reset or flush: all entries invalid, count=0. full_o=0, readyRS_o=0, all data outputs 0.
- Storage is an age-ordered compacting queue. Entry 0 is oldest. Per entry: valid, rdy1, rdy2, Q1, Q2, val1, val2, commands, tag.
- Issue candidate: lowest-index entry with valid&rdy1&rdy2.
  - Outputs are combinational from the stored entry: readyRS_o=1 and data = candidate fields. Otherwise readyRS_o=0 and data=0.
  - readyRS_o must not depend combinationally on stallRS_i or any same-cycle input. stallRS_i is combinational from readyRS_o in the exec stage.
- Transfer occurs at posedge when readyRS_o & ~stallRS_i. The issued entry is removed and all younger entries shift down one slot, same edge.
- Dispatch: when dispatchValid_i & ~full_o, write the new op to slot (count - issued).
  - Simultaneous issue and dispatch gives net count unchanged.
  - Dispatch while full_o=1 is dropped; state unchanged.
- full_o is registered-state only; a same-cycle issue does not free a slot for dispatch.
- CDB capture: for every valid entry with rdyN=0 and QN==cdbTag_i while cdbValid_i, set valN=cdbVal_i and rdyN=1 at that edge. It applies to surviving entries after shift; no same-cycle issue of newly woken entries.
- Both operands of one entry may match the same broadcast; both capture.
- Flush: highest priority. Flush_i clears everything at the edge and ignores same-cycle dispatch, issue and CDB.
- Reset mid-operation behaves the same as flush.
- Latency: op dispatched with both operands ready gives readyRS_o=1 the next cycle. Operand woken by CDB gives readyRS_o=1 the cycle after the broadcast.

Optional Feature:
- DIV_RS_CDB_BYPASS_EN defined:
  - A dispatching op whose not-ready operand has QN==cdbTag_i with cdbValid_i in the same cycle stores cdbVal_i and rdyN=1.
  - readyRS_o can then assert next cycle.
- Undefined:
  - No bypass; the operand is stored not-ready.
  - Upstream rename must already resolve same-cycle broadcasts, or the entry waits forever.

Test Plan:
- Reset, then dispatch {val1=15, val2=3, cmd=10, tag=3, both ready}, stallRS_i=0 -> next cycle readyRS_o=1, outputs 15/3/10/3. Following cycle readyRS_o=0, count 0.
- Dispatch tag=1 (Q2=5, not ready), then tag=2 (ready) -> tag 2 issues first. Then CDB tag=5 val=7 -> next cycle tag 1 issues with val2=7.
- Hold stallRS_i=1 while dispatching 4 ready ops (tags 4..7) -> full_o=1, 5th dispatch dropped, outputs stay on tag 4. Release stall -> tags 4,5,6,7 issue in order over 4 cycles.
- Full station, issue and dispatch same cycle -> dispatch dropped, count becomes 3, full_o=0 next cycle.
- Two entries waiting on Q1=9; flush_i asserted same cycle as CDB tag=9 -> all entries cleared, readyRS_o=0, full_o=0.
- With DIV_RS_CDB_BYPASS_EN: dispatch Q1=6 not ready while CDB tag=6 val=100 -> readyRS_o=1 next cycle, Val1=100. Without it -> readyRS_o stays 0.

Source files
------------

// File: rtl/div_reservation_station.sv
// Divider reservation station: age-ordered compacting queue, oldest ready op issues first; DIV_RS_CDB_BYPASS_EN captures a same-cycle CDB on dispatch.
// Dispatch-to-ready and CDB-to-ready are one cycle; the candidate is held while stallRS_i is high and dispatch is dropped when full_o.
module div_reservation_station #(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int RSsize     = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  dispatchValid_i,
  input  logic [9:0]            dispatchCommands_i,
  input  logic [ROBsizeLog-1:0] dispatchTag_i,
  input  logic [63:0]           dispatchVal1_i,
  input  logic [63:0]           dispatchVal2_i,
  input  logic                  dispatchRdy1_i,
  input  logic                  dispatchRdy2_i,
  input  logic [ROBsizeLog-1:0] dispatchQ1_i,
  input  logic [ROBsizeLog-1:0] dispatchQ2_i,
  output logic                  full_o,
  input  logic                  cdbValid_i,
  input  logic [ROBsizeLog-1:0] cdbTag_i,
  input  logic [63:0]           cdbVal_i,
  input  logic                  flush_i,
  output logic                  readyRS_o,
  input  logic                  stallRS_i,
  output logic [63:0]           reservationStationVal1_o,
  output logic [63:0]           reservationStationVal2_o,
  output logic [9:0]            reservationStationCommands_o,
  output logic [ROBsizeLog-1:0] reservationStationTag_o
);

  localparam int CW = $clog2(RSsize + 1);
  localparam int IW = $clog2(RSsize);
  localparam logic [CW-1:0] FullCount = CW'(RSsize);

  typedef struct packed {
    logic                  valid;
    logic                  rdy1;
    logic                  rdy2;
    logic [ROBsizeLog-1:0] q1;
    logic [ROBsizeLog-1:0] q2;
    logic [63:0]           val1;
    logic [63:0]           val2;
    logic [9:0]            commands;
    logic [ROBsizeLog-1:0] tag;
  } entry_t;

  entry_t          entries    [RSsize];
  entry_t          entriesNxt [RSsize];
  entry_t          dispatchEntry;
  logic [CW-1:0]   count;
  logic [CW-1:0]   countNxt;
  logic [CW-1:0]   dispatchSlot;
  logic            candFound;
  logic [IW-1:0]   candIdx;
  logic            issue;
  logic            accept;

  // Scan from the youngest down so the last hit is the oldest ready entry.
  always_comb begin
    candFound = 1'b0;
    candIdx   = '0;
    for (int i = RSsize - 1; i >= 0; i--) begin
      if (entries[i].valid && entries[i].rdy1 && entries[i].rdy2) begin
        candFound = 1'b1;
        candIdx   = IW'(i);
      end
    end
  end

  assign full_o                       = (count == FullCount);
  assign readyRS_o                    = candFound;
  assign reservationStationVal1_o     = candFound ? entries[candIdx].val1 : '0;
  assign reservationStationVal2_o     = candFound ? entries[candIdx].val2 : '0;
  assign reservationStationCommands_o = candFound ? entries[candIdx].commands : '0;
  assign reservationStationTag_o      = candFound ? entries[candIdx].tag : '0;

  assign issue        = candFound & ~stallRS_i;
  assign accept       = dispatchValid_i & ~full_o;
  assign dispatchSlot = count - CW'(issue);
  assign countNxt     = count - CW'(issue) + CW'(accept);

  always_comb begin
    dispatchEntry          = '0;
    dispatchEntry.valid    = 1'b1;
    dispatchEntry.rdy1     = dispatchRdy1_i;
    dispatchEntry.rdy2     = dispatchRdy2_i;
    dispatchEntry.q1       = dispatchQ1_i;
    dispatchEntry.q2       = dispatchQ2_i;
    dispatchEntry.val1     = dispatchVal1_i;
    dispatchEntry.val2     = dispatchVal2_i;
    dispatchEntry.commands = dispatchCommands_i;
    dispatchEntry.tag      = dispatchTag_i;
`ifdef DIV_RS_CDB_BYPASS_EN
    if (cdbValid_i && !dispatchRdy1_i && dispatchQ1_i == cdbTag_i) begin
      dispatchEntry.rdy1 = 1'b1;
      dispatchEntry.val1 = cdbVal_i;
    end
    if (cdbValid_i && !dispatchRdy2_i && dispatchQ2_i == cdbTag_i) begin
      dispatchEntry.rdy2 = 1'b1;
      dispatchEntry.val2 = cdbVal_i;
    end
`endif
  end

  // Order matters: compact first, then wake survivors, then append the new op
  // so a plain dispatch never sees this cycle's broadcast.
  always_comb begin
    for (int i = 0; i < RSsize; i++) entriesNxt[i] = entries[i];
    if (issue) begin
      for (int i = 0; i < RSsize - 1; i++) begin
        if (i >= int'(candIdx)) entriesNxt[i] = entries[i+1];
      end
      entriesNxt[RSsize-1] = '0;
    end
    if (cdbValid_i) begin
      for (int i = 0; i < RSsize; i++) begin
        if (entriesNxt[i].valid && !entriesNxt[i].rdy1 && entriesNxt[i].q1 == cdbTag_i) begin
          entriesNxt[i].rdy1 = 1'b1;
          entriesNxt[i].val1 = cdbVal_i;
        end
        if (entriesNxt[i].valid && !entriesNxt[i].rdy2 && entriesNxt[i].q2 == cdbTag_i) begin
          entriesNxt[i].rdy2 = 1'b1;
          entriesNxt[i].val2 = cdbVal_i;
        end
      end
    end
    if (accept) begin
      for (int i = 0; i < RSsize; i++) begin
        if (i == int'(dispatchSlot)) entriesNxt[i] = dispatchEntry;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      for (int i = 0; i < RSsize; i++) entries[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < RSsize; i++) entries[i] <= entriesNxt[i];
      count <= countNxt;
    end
  end

endmodule

// File: tb/tb_div_reservation_station.sv
// Bench for div_reservation_station: directed scenarios then random traffic against a queue model.
module tb_div_reservation_station;

  localparam int TW = 6;
  localparam int RSN = 4;

  logic          clk_i = 1'b0;
  logic          reset_i, dispatchValid_i, dispatchRdy1_i, dispatchRdy2_i;
  logic [9:0]    dispatchCommands_i;
  logic [TW-1:0] dispatchTag_i, dispatchQ1_i, dispatchQ2_i, cdbTag_i;
  logic [63:0]   dispatchVal1_i, dispatchVal2_i, cdbVal_i;
  logic          cdbValid_i, flush_i, stallRS_i;
  logic          full_o, readyRS_o;
  logic [63:0]   reservationStationVal1_o, reservationStationVal2_o;
  logic [9:0]    reservationStationCommands_o;
  logic [TW-1:0] reservationStationTag_o;

  int nChecks = 0;
  int nFails  = 0;

  div_reservation_station dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dispatchValid_i(dispatchValid_i), .dispatchCommands_i(dispatchCommands_i),
    .dispatchTag_i(dispatchTag_i), .dispatchVal1_i(dispatchVal1_i), .dispatchVal2_i(dispatchVal2_i),
    .dispatchRdy1_i(dispatchRdy1_i), .dispatchRdy2_i(dispatchRdy2_i),
    .dispatchQ1_i(dispatchQ1_i), .dispatchQ2_i(dispatchQ2_i), .full_o(full_o),
    .cdbValid_i(cdbValid_i), .cdbTag_i(cdbTag_i), .cdbVal_i(cdbVal_i), .flush_i(flush_i),
    .readyRS_o(readyRS_o), .stallRS_i(stallRS_i),
    .reservationStationVal1_o(reservationStationVal1_o),
    .reservationStationVal2_o(reservationStationVal2_o),
    .reservationStationCommands_o(reservationStationCommands_o),
    .reservationStationTag_o(reservationStationTag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          r1, r2;
    bit [TW-1:0] q1, q2;
    bit [63:0]   v1, v2;
    bit [9:0]    cmd;
    bit [TW-1:0] tag;
  } op_t;

  op_t rs[$];

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int firstReady();
    foreach (rs[i]) if (rs[i].r1 && rs[i].r2) return i;
    return -1;
  endfunction

  // Model of one clock edge, built from the queue rules rather than slots.
  task automatic modelStep();
    int  idx;
    bit  acc;
    op_t n;
    if (reset_i || flush_i) begin
      rs.delete();
      return;
    end
    idx = firstReady();
    acc = dispatchValid_i && (rs.size() < RSN);
    if (idx >= 0 && !stallRS_i) rs.delete(idx);
    if (cdbValid_i) begin
      foreach (rs[i]) begin
        if (!rs[i].r1 && rs[i].q1 == cdbTag_i) begin rs[i].r1 = 1; rs[i].v1 = cdbVal_i; end
        if (!rs[i].r2 && rs[i].q2 == cdbTag_i) begin rs[i].r2 = 1; rs[i].v2 = cdbVal_i; end
      end
    end
    if (acc) begin
      n.r1 = dispatchRdy1_i; n.r2 = dispatchRdy2_i;
      n.q1 = dispatchQ1_i;   n.q2 = dispatchQ2_i;
      n.v1 = dispatchVal1_i; n.v2 = dispatchVal2_i;
      n.cmd = dispatchCommands_i; n.tag = dispatchTag_i;
`ifdef DIV_RS_CDB_BYPASS_EN
      if (cdbValid_i && !n.r1 && n.q1 == cdbTag_i) begin n.r1 = 1; n.v1 = cdbVal_i; end
      if (cdbValid_i && !n.r2 && n.q2 == cdbTag_i) begin n.r2 = 1; n.v2 = cdbVal_i; end
`endif
      rs.push_back(n);
    end
  endtask

  task automatic checkOutputs();
    int idx;
    idx = firstReady();
    checkEq("full", 64'(full_o), 64'(rs.size() == RSN));
    checkEq("readyRS", 64'(readyRS_o), 64'(idx >= 0));
    checkEq("val1", reservationStationVal1_o, (idx >= 0) ? rs[idx].v1 : 64'd0);
    checkEq("val2", reservationStationVal2_o, (idx >= 0) ? rs[idx].v2 : 64'd0);
    checkEq("cmd", 64'(reservationStationCommands_o), (idx >= 0) ? 64'(rs[idx].cmd) : 64'd0);
    checkEq("tag", 64'(reservationStationTag_o), (idx >= 0) ? 64'(rs[idx].tag) : 64'd0);
  endtask

  // Inputs are changed just after a falling edge; outputs are sampled on the next one.
  task automatic tick();
    modelStep();
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutputs();
  endtask

  task automatic clearIn();
    reset_i = 0; dispatchValid_i = 0; dispatchCommands_i = 0; dispatchTag_i = 0;
    dispatchVal1_i = 0; dispatchVal2_i = 0; dispatchRdy1_i = 0; dispatchRdy2_i = 0;
    dispatchQ1_i = 0; dispatchQ2_i = 0; cdbValid_i = 0; cdbTag_i = 0; cdbVal_i = 0;
    flush_i = 0; stallRS_i = 0;
  endtask

  task automatic setDispatch(input logic [TW-1:0] tag, input logic [63:0] v1, input logic [63:0] v2,
                             input logic [9:0] cmd, input logic r1, input logic r2,
                             input logic [TW-1:0] q1, input logic [TW-1:0] q2);
    dispatchValid_i = 1; dispatchTag_i = tag; dispatchVal1_i = v1; dispatchVal2_i = v2;
    dispatchCommands_i = cmd; dispatchRdy1_i = r1; dispatchRdy2_i = r2;
    dispatchQ1_i = q1; dispatchQ2_i = q2;
  endtask

  initial begin
    clearIn();
    reset_i = 1;
    tick(); tick();
    checkEq("reset_ready", 64'(readyRS_o), 64'd0);
    checkEq("reset_full", 64'(full_o), 64'd0);
    reset_i = 0;

    // Single ready op issues the cycle after dispatch.
    setDispatch(3, 15, 3, 10, 1, 1, 0, 0);
    tick();
    dispatchValid_i = 0;
    checkEq("t1_ready", 64'(readyRS_o), 64'd1);
    checkEq("t1_val1", reservationStationVal1_o, 64'd15);
    checkEq("t1_val2", reservationStationVal2_o, 64'd3);
    checkEq("t1_cmd", 64'(reservationStationCommands_o), 64'd10);
    checkEq("t1_tag", 64'(reservationStationTag_o), 64'd3);
    tick();
    checkEq("t1_drained", 64'(readyRS_o), 64'd0);

    // Younger ready op overtakes an older waiting one; CDB wakes the older.
    setDispatch(1, 20, 0, 11, 1, 0, 0, 5);
    tick();
    setDispatch(2, 30, 6, 12, 1, 1, 0, 0);
    tick();
    dispatchValid_i = 0;
    checkEq("t2_first_tag", 64'(reservationStationTag_o), 64'd2);
    tick();
    cdbValid_i = 1; cdbTag_i = 5; cdbVal_i = 7;
    tick();
    cdbValid_i = 0;
    checkEq("t2_woken_tag", 64'(reservationStationTag_o), 64'd1);
    checkEq("t2_woken_val2", reservationStationVal2_o, 64'd7);
    tick();

    // Fill under stall, drop the fifth, then drain in age order.
    stallRS_i = 1;
    for (int t = 4; t < 8; t++) begin
      setDispatch(TW'(t), 64'(t * 100), 64'(t), 10'(t), 1, 1, 0, 0);
      tick();
    end
    checkEq("t3_full", 64'(full_o), 64'd1);
    setDispatch(8, 800, 8, 8, 1, 1, 0, 0);
    tick();
    dispatchValid_i = 0;
    checkEq("t3_hold_tag", 64'(reservationStationTag_o), 64'd4);
    stallRS_i = 0;
    for (int t = 4; t < 8; t++) begin
      checkEq("t3_order", 64'(reservationStationTag_o), 64'(t));
      tick();
    end
    checkEq("t3_empty", 64'(readyRS_o), 64'd0);

    // Issue and dispatch together on a full station: dispatch is dropped.
    stallRS_i = 1;
    for (int t = 10; t < 14; t++) begin
      setDispatch(TW'(t), 64'(t), 64'(t + 1), 10'(t), 1, 1, 0, 0);
      tick();
    end
    stallRS_i = 0;
    setDispatch(20, 1, 1, 1, 1, 1, 0, 0);
    tick();
    dispatchValid_i = 0;
    checkEq("t4_not_full", 64'(full_o), 64'd0);
    tick(); tick();
    checkEq("t4_last_tag", 64'(reservationStationTag_o), 64'd13);
    tick();
    checkEq("t4_empty", 64'(readyRS_o), 64'd0);

    // Flush wins over a same-cycle CDB wakeup.
    setDispatch(21, 0, 2, 3, 0, 1, 9, 0);
    tick();
    setDispatch(22, 0, 4, 5, 0, 1, 9, 0);
    tick();
    dispatchValid_i = 0;
    flush_i = 1; cdbValid_i = 1; cdbTag_i = 9; cdbVal_i = 99;
    tick();
    flush_i = 0; cdbValid_i = 0;
    checkEq("t5_ready", 64'(readyRS_o), 64'd0);
    checkEq("t5_full", 64'(full_o), 64'd0);
    tick();
    checkEq("t5_still_empty", 64'(readyRS_o), 64'd0);

    // Dispatch racing a CDB broadcast for its own operand.
    setDispatch(23, 0, 5, 6, 0, 1, 6, 0);
    cdbValid_i = 1; cdbTag_i = 6; cdbVal_i = 100;
    tick();
    clearIn();
`ifdef DIV_RS_CDB_BYPASS_EN
    checkEq("t6_bypass_ready", 64'(readyRS_o), 64'd1);
    checkEq("t6_bypass_val1", reservationStationVal1_o, 64'd100);
`else
    checkEq("t6_nobypass_ready", 64'(readyRS_o), 64'd0);
`endif
    flush_i = 1;
    tick();
    flush_i = 0;

    // Random traffic with a small tag space so CDB hits are frequent.
    for (int c = 0; c < 400; c++) begin
      reset_i = ($urandom_range(0, 199) == 0);
      flush_i = ($urandom_range(0, 59) == 0);
      dispatchValid_i = $urandom_range(0, 1) == 1;
      dispatchTag_i = TW'($urandom_range(0, 31));
      dispatchCommands_i = 10'($urandom_range(0, 1023));
      dispatchVal1_i = {$urandom, $urandom};
      dispatchVal2_i = {$urandom, $urandom};
      dispatchRdy1_i = $urandom_range(0, 2) != 0;
      dispatchRdy2_i = $urandom_range(0, 2) != 0;
      dispatchQ1_i = TW'($urandom_range(0, 7));
      dispatchQ2_i = TW'($urandom_range(0, 7));
      cdbValid_i = $urandom_range(0, 2) == 0;
      cdbTag_i = TW'($urandom_range(0, 7));
      cdbVal_i = {$urandom, $urandom};
      stallRS_i = $urandom_range(0, 2) == 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
